sprite_rom_arbiter: RTL and testbench

Round-robin arbiter that shares one sprite frameRAM read port (19-bit address, 24-bit RGB data, registered output) among NUM_REQ sprite drawers (tanks, bullets, HUD).
Each cycle it grants at most one requester, drives the ROM address, and pipelines the requester ID through the ROM read latency.
It returns each pixel tagged with its requester ID.
It sits between the per-object draw logic and the shared frameRAM instance, ahead of the color mapper.

---
 rtl/sprite_rom_arbiter.sv | 120 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite frameRAM read port among NUM_REQ drawers.
// Define SPRITE_ARB_TRANSPARENT_EN to add the chroma-key flag rsp_transparent.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
`ifdef SPRITE_ARB_TRANSPARENT_EN
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_transparent
`else
    output logic [DATA_W-1:0]            rsp_data
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_pv  [ROM_LAT];
    logic [ID_W-1:0]    r_pid [ROM_LAT];

    logic               w_any;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0] w_gnt;
    logic [DATA_W-1:0]  w_pix;

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin : arb
        logic [ID_W-1:0] v_idx;
        v_idx    = '0;
        w_any    = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid[v_idx]) begin
                w_any    = 1'b1;
                w_gnt_id = v_idx;
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_any)
            w_gnt[w_gnt_id] = 1'b1;
    end

    assign w_ptr_nxt = ID_W'((int'(w_gnt_id) + 1) % NUM_REQ);
    assign req_ready = w_gnt;
    assign rom_addr  = w_any ? req_addr[w_gnt_id*ADDR_W +: ADDR_W] : r_addr;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr  <= '0;
            r_addr <= '0;
        end else if (w_any) begin
            r_ptr  <= w_ptr_nxt;
            r_addr <= rom_addr;
        end
    end

    // {valid,id} travel alongside the ROM read so the pixel can be tagged.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                r_pv[k]  <= 1'b0;
                r_pid[k] <= '0;
            end
        end else begin
            r_pv[0]  <= w_any;
            r_pid[0] <= w_gnt_id;
            for (int k = 1; k < ROM_LAT; k++) begin
                r_pv[k]  <= r_pv[k-1];
                r_pid[k] <= r_pid[k-1];
            end
        end
    end

`ifdef SPRITE_ARB_TRANSPARENT_EN
    logic w_key;
    assign w_key = (rom_data == DATA_W'(24'hFF0000));
    // Keyed pixels go out black so layers can be OR-mixed downstream.
    assign w_pix = w_key ? '0 : rom_data;
`else
    assign w_pix = rom_data;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
`ifdef SPRITE_ARB_TRANSPARENT_EN
            rsp_transparent <= 1'b0;
`endif
        end else begin
            rsp_valid <= r_pv[ROM_LAT-1];
            if (r_pv[ROM_LAT-1]) begin
                rsp_id   <= r_pid[ROM_LAT-1];
                rsp_data <= w_pix;
`ifdef SPRITE_ARB_TRANSPARENT_EN
                rsp_transparent <= w_key;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed steps then random traffic, two ROM latencies.
// Expected grants/responses come from a round-robin model and a grant history.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 24;
    localparam int ID_W    = 2;
    localparam int HMAX    = 4096;

    logic                      Clk = 1'b0;
    logic                      Reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;

    logic [NUM_REQ-1:0] rdy1, rdy3;
    logic [ADDR_W-1:0]  ra1, ra3;
    logic [DATA_W-1:0]  rom1, rom3, d1, d3;
    logic [DATA_W-1:0]  r3a, r3b;
    logic               v1, v3;
    logic [ID_W-1:0]    id1, id3;
    logic               tr1, tr3;

    always #5 Clk = ~Clk;

    sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) u_l1 (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy1), .rom_addr(ra1), .rom_data(rom1),
        .rsp_valid(v1), .rsp_id(id1),
`ifdef SPRITE_ARB_TRANSPARENT_EN
        .rsp_data(d1), .rsp_transparent(tr1)
`else
        .rsp_data(d1)
`endif
    );

    sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(3)) u_l3 (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy3), .rom_addr(ra3), .rom_data(rom3),
        .rsp_valid(v3), .rsp_id(id3),
`ifdef SPRITE_ARB_TRANSPARENT_EN
        .rsp_data(d3), .rsp_transparent(tr3)
`else
        .rsp_data(d3)
`endif
    );

`ifndef SPRITE_ARB_TRANSPARENT_EN
    assign tr1 = 1'b0;
    assign tr3 = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] romf(input logic [ADDR_W-1:0] a);
        if (a == 19'h00123) return 24'h142608;
        if (a == 19'h00007) return 24'hFF0000;
        if (a == 19'h00008) return 24'h3D3D3D;
        return {a, 5'h0} ^ 24'h5A5A5A;
    endfunction

    // Behavioural frameRAMs with 1 and 3 clock edges of read latency
    always @(posedge Clk) begin
        rom1 <= romf(ra1);
        r3a  <= romf(ra3);
        r3b  <= r3a;
        rom3 <= r3b;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int m_ptr = 0;
    int last_g = -1;
    logic [ADDR_W-1:0] m_last = '0;
    logic              hv [HMAX];
    int                hid [HMAX];
    logic [ADDR_W-1:0] ha [HMAX];
    int                wt [NUM_REQ];
    int                e_id [2];
    logic [DATA_W-1:0] e_data [2];
    logic              e_tr [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        base   = cyc;
        m_ptr  = 0;
        m_last = '0;
        for (int w = 0; w < 2; w++) begin
            e_id[w]   = 0;
            e_data[w] = '0;
            e_tr[w]   = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) wt[i] = 0;
    endtask

    task automatic chk_rsp(input int w, input int lat, input logic v,
                           input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                           input logic tr);
        int g;
        logic ev;
        logic [DATA_W-1:0] pix;
        g  = cyc - lat - 1;
        ev = (g >= base) && hv[g];
        if (ev) begin
            e_id[w] = hid[g];
            pix     = romf(ha[g]);
`ifdef SPRITE_ARB_TRANSPARENT_EN
            e_tr[w]   = (pix == 24'hFF0000);
            e_data[w] = e_tr[w] ? 24'h0 : pix;
`else
            e_data[w] = pix;
`endif
        end
        chk($sformatf("rsp_valid_L%0d", lat), 64'(v), 64'(ev));
        chk($sformatf("rsp_id_L%0d", lat), 64'(id), 64'(e_id[w]));
        chk($sformatf("rsp_data_L%0d", lat), 64'(d), 64'(e_data[w]));
`ifdef SPRITE_ARB_TRANSPARENT_EN
        chk($sformatf("rsp_transparent_L%0d", lat), 64'(tr), 64'(e_tr[w]));
`else
        if (tr !== 1'b0) chk("tr_tied", 64'(tr), 64'(0));
`endif
    endtask

    // One clock cycle: check at the falling edge, then advance the model.
    task automatic step();
        int g;
        logic [NUM_REQ-1:0] erdy;
        logic [ADDR_W-1:0]  eaddr;
        @(negedge Clk);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        erdy  = (g >= 0) ? NUM_REQ'(1 << g) : '0;
        eaddr = (g >= 0) ? req_addr[g*ADDR_W +: ADDR_W] : m_last;
        chk("req_ready_L1", 64'(rdy1), 64'(erdy));
        chk("req_ready_L3", 64'(rdy3), 64'(erdy));
        chk("rom_addr_L1", 64'(ra1), 64'(eaddr));
        chk("rom_addr_L3", 64'(ra3), 64'(eaddr));
        chk_rsp(0, 1, v1, id1, d1, tr1);
        chk_rsp(1, 3, v3, id3, d3, tr3);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i]) wt[i] = 0;
            else if (g == i) begin
                chk("fair_wait_ok", 64'(wt[i] <= NUM_REQ - 1), 64'(1));
                wt[i] = 0;
            end else wt[i]++;
        end
        hv[cyc]  = (g >= 0);
        hid[cyc] = (g >= 0) ? g : 0;
        ha[cyc]  = eaddr;
        if (g >= 0) begin
            m_ptr  = (g + 1) % NUM_REQ;
            m_last = eaddr;
        end
        last_g = g;
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) begin
            @(negedge Clk);
            chk("rst_rsp_valid_L1", 64'(v1), 64'(0));
            chk("rst_rsp_valid_L3", 64'(v3), 64'(0));
            chk("rst_rsp_id_L1", 64'(id1), 64'(0));
            chk("rst_rsp_data_L3", 64'(d3), 64'(0));
            hv[cyc] = 1'b0;
            cyc++;
            @(posedge Clk);
            #1;
        end
        Reset = 1'b0;
        clear_model();
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 19'h00007;
            1: return 19'h00008;
            2: return 19'h00123;
            default: return ADDR_W'($urandom);
        endcase
    endfunction

    // Requesters hold valid/addr until granted, then may re-request or idle.
    task automatic rnd_drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || last_g == i) begin
                if ($urandom_range(0, 99) < 55) begin
                    req_valid[i] = 1'b1;
                    set_addr(i, pick_addr());
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < HMAX; i++) hv[i] = 1'b0;
        clear_model();
        do_reset(2);

        // single request, fixed pixel
        req_valid = 4'b0001;
        set_addr(0, 19'h00123);
        step();
        req_valid = '0;
        step();
        chk("t1_rsp_data", 64'(d1), 64'(24'h142608));
        chk("t1_rsp_valid", 64'(v1), 64'(1));
        repeat (4) step();

        // all requesters continuously valid
        do_reset(1);
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 19'h00100 + 19'(i));
        req_valid = 4'b1111;
        repeat (8) step();
        req_valid = '0;
        repeat (5) step();

        // pointer wrap with only the low two requesters
        do_reset(1);
        req_valid = 4'b0011;
        set_addr(0, 19'h00008);
        set_addr(1, 19'h00031);
        repeat (4) step();
        req_valid = '0;
        repeat (5) step();

        // grant then reset on the next cycle discards it
        req_valid = 4'b0100;
        set_addr(2, 19'h00055);
        step();
        req_valid = 4'b0110;
        do_reset(1);
        step();
        req_valid = '0;
        repeat (6) step();

        // chroma key and ordinary pixel
        req_valid = 4'b0001;
        set_addr(0, 19'h00007);
        step();
        set_addr(0, 19'h00008);
        step();
        req_valid = '0;
        repeat (5) step();

        // random traffic with a mid-run reset
        for (int n = 0; n < 300; n++) begin
            rnd_drive();
            if (n == 150) do_reset(2);
            step();
        end
        req_valid = '0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
